// File: rtl/ising_run_ctrl.sv
// Run sequencer for the coupled-oscillator array: reset hold, timed anneal, majority-vote spin readout.
// Latency: done rises HOLD_CYCLES + run length + SAMPLE_CYCLES edges after start is accepted.
// Backpressure: none. Host weight writes are dropped while busy, and each dropped write raises a 1-cycle wr_blocked pulse.
// Ports: clk, axi_rst (async, active-high); start/abort/run_cycles control a run;
//        phase_in = raw oscillator outputs; host_wready -> cell_wready is the gated write strobe;
//        wr_blocked, ising_rstn, busy, done and spins report status and the result.
module ising_run_ctrl #(
  parameter int N             = 8,
  parameter int HOLD_CYCLES   = 4,
  parameter int SAMPLE_CYCLES = 63
) (
  input  logic          clk,
  input  logic          axi_rst,
  input  logic          start,
  input  logic          abort,
  input  logic [31:0]   run_cycles,
  input  logic [N-1:0]  phase_in,
  input  logic          host_wready,
  output logic          cell_wready,
  output logic          wr_blocked,
  output logic          ising_rstn,
  output logic          busy,
  output logic          done,
  output logic [N-1:0]  spins
);

  localparam int MW = $clog2(SAMPLE_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, HOLD, RUN, SAMPLE, DONE} state_t;

  state_t         state, state_nxt;
  logic           accept;
  logic [31:0]    cnt;
  logic [31:0]    run_len;
  logic [N-1:0]   sync1, sync2;
  logic [N-1:0]   hit;
  logic [N-1:0]   vote;
  logic [MW-1:0]  match_cnt [N];
  logic           last_hold, last_run, last_sample;

  // cnt counts cycles spent in the current busy state and restarts on every transition.
  assign last_hold   = (cnt == 32'(HOLD_CYCLES - 1));
  assign last_run    = (cnt == run_len - 32'd1);
  assign last_sample = (cnt == 32'(SAMPLE_CYCLES - 1));

  assign busy        = (state == HOLD) || (state == RUN) || (state == SAMPLE);
  assign done        = (state == DONE);
  assign ising_rstn  = (state == RUN) || (state == SAMPLE);
  assign cell_wready = host_wready && ((state == IDLE) || (state == DONE));

  // Oscillator i is in phase with the reference oscillator 0.
  assign hit = ~(sync2 ^ {N{sync2[0]}});

  always_ff @(posedge clk or posedge axi_rst) begin
    if (axi_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE, DONE: begin
        // abort outranks start, even though abort does nothing else here
        if (start && !abort) begin
          accept    = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (abort)          state_nxt = IDLE;
        else if (last_hold) state_nxt = RUN;
      end
      RUN: begin
        if (abort)         state_nxt = IDLE;
        else if (last_run) state_nxt = SAMPLE;
      end
      SAMPLE: begin
        if (abort)            state_nxt = IDLE;
        else if (last_sample) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The final vote includes the compare made on the last sample cycle.
  // A tie gives 2*count == SAMPLE_CYCLES, which is not greater, so it resolves to 0.
  always_comb begin
    logic [MW+1:0] dbl;
    vote = '0;
    for (int i = 0; i < N; i++) begin
      dbl     = (MW+2)'(match_cnt[i]) + (MW+2)'(hit[i]);
      dbl     = dbl << 1;
      vote[i] = (dbl > (MW+2)'(SAMPLE_CYCLES));
    end
  end

  always_ff @(posedge clk or posedge axi_rst) begin
    if (axi_rst) begin
      cnt        <= '0;
      run_len    <= '0;
      sync1      <= '0;
      sync2      <= '0;
      spins      <= '0;
      wr_blocked <= 1'b0;
      for (int i = 0; i < N; i++) match_cnt[i] <= '0;
    end else begin
      sync1      <= phase_in;
      sync2      <= sync1;
      wr_blocked <= host_wready && busy;

      if (state_nxt != state) cnt <= '0;
      else if (busy)          cnt <= cnt + 32'd1;

      // A zero length is treated as one cycle. The full 32-bit range counts up without wrapping.
      if (accept) run_len <= (run_cycles == 32'd0) ? 32'd1 : run_cycles;

      for (int i = 0; i < N; i++) begin
        if (state == RUN && state_nxt == SAMPLE)
          match_cnt[i] <= '0;
        else if (state == SAMPLE && hit[i])
          match_cnt[i] <= match_cnt[i] + MW'(1);
      end

      if (state == SAMPLE && state_nxt == DONE) spins <= vote;
    end
  end

endmodule
